// File: rtl/ram_prog_pkg.sv
// Shared types and sizes for the 16-byte program RAM loader.
package ram_prog_pkg;

    localparam int RAM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_FILL    = 2'd2,
        ST_RELEASE = 2'd3
    } prog_state_e;

endpackage

// File: rtl/prog_timer.sv
// Idle-cycle counter for LOAD; tc fires on the cycle whose increment reaches TIMEOUT_CYCLES.
module prog_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Clear has priority so a transfer on the terminal cycle suppresses the timeout.
    assign tc = enable && !clear && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_prog_ctrl.sv
// Loads 16 program bytes into the CPU RAM, zero-fills on abort/timeout, then pulses CPU reset.
module ram_prog_ctrl
    import ram_prog_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] program_data,
    output logic              cpu_halt,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done
);

    // Index is one bit wider than the address so it can reach RAM_DEPTH without wrapping.
    localparam int IDX_W = ADDR_W + 1;
    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

    prog_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [REL_W-1:0]  rel_q, rel_d;
    logic              prog_mode_q, prog_mode_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [DATA_W-1:0] prog_data_q, prog_data_d;
    logic              done_q, done_d;

    logic xfer;
    logic last_idx;
    logic timer_clear;
    logic timer_en;
    logic timer_tc;

    // Handshake: a byte moves on every cycle where in_valid and in_ready are both high.
    assign in_ready    = (state_q == ST_LOAD);
    assign xfer        = in_ready && in_valid;
    assign last_idx    = (idx_q == IDX_W'(RAM_DEPTH - 1));
    assign timer_clear = (state_q != ST_LOAD) || xfer;
    assign timer_en    = (state_q == ST_LOAD) && !xfer;

    prog_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rel_d       = rel_q;
        prog_mode_d = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        done_d      = done_q;
        unique case (state_q)
            ST_IDLE: begin
                rel_d = '0;
                if (load_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    prog_mode_d = 1'b1;
                    prog_addr_d = idx_q[ADDR_W-1:0];
                    prog_data_d = in_data;
                    idx_d       = idx_q + IDX_W'(1);
                end
                // A final-byte transfer leaves nothing to fill, whatever abort/timeout say.
                if (xfer && last_idx) begin
                    state_d = ST_RELEASE;
                end else if (load_abort || timer_tc) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                prog_mode_d = 1'b1;
                prog_addr_d = idx_q[ADDR_W-1:0];
                prog_data_d = '0;
                idx_d       = idx_q + IDX_W'(1);
                if (last_idx) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rel_d = rel_q + REL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rel_q       <= '0;
            prog_mode_q <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rel_q       <= rel_d;
            prog_mode_q <= prog_mode_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            done_q      <= done_d;
        end
    end

    assign prog_mode    = prog_mode_q;
    assign prog_addr    = prog_addr_q;
    assign program_data = prog_data_q;
    assign done         = done_q;
    assign busy         = (state_q != ST_IDLE);
    assign cpu_halt     = (state_q != ST_IDLE);
    assign cpu_reset    = (state_q == ST_RELEASE);

endmodule

// File: tb/tb_ram_prog_ctrl.sv
// Directed bench for ram_prog_ctrl: cycle model compared every cycle plus literal end-of-load checks.
module tb_ram_prog_ctrl;

    localparam int TIMEOUT = 255;
    localparam int RELCYC  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       load_abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, prog_mode, cpu_halt, cpu_reset, busy, done;
    logic [3:0] prog_addr;
    logic [7:0] program_data;

    int checks = 0;
    int errors = 0;

    ram_prog_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .RELEASE_CYCLES(RELCYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_abort   (load_abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .prog_mode    (prog_mode),
        .prog_addr    (prog_addr),
        .program_data (program_data),
        .cpu_halt     (cpu_halt),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 intake, 2 zero-fill, 3 cpu reset pulse.
    int         m_ph = 0;
    int         m_idx = 0;
    int         m_idle = 0;
    int         m_rel = 0;
    logic       m_pm = 1'b0;
    logic [3:0] m_addr = 4'h0;
    logic [7:0] m_data = 8'h00;
    logic       m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_idx = 0; m_idle = 0; m_rel = 0;
            m_pm = 1'b0; m_addr = 4'h0; m_data = 8'h00; m_done = 1'b0;
        end else begin
            m_pm = 1'b0;
            case (m_ph)
                0: if (load_start) begin
                    m_ph = 1; m_idx = 0; m_idle = 0; m_done = 1'b0;
                end
                1: begin
                    if (in_valid) begin
                        m_pm = 1'b1; m_addr = 4'(m_idx); m_data = in_data;
                        m_idx++; m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                    if (m_idx == 16) begin
                        m_ph = 3; m_rel = 0;
                    end else if (load_abort || m_idle == TIMEOUT) begin
                        m_ph = 2;
                    end
                end
                2: begin
                    m_pm = 1'b1; m_addr = 4'(m_idx); m_data = 8'h00; m_idx++;
                    if (m_idx == 16) begin
                        m_ph = 3; m_rel = 0;
                    end
                end
                default: begin
                    m_rel++;
                    if (m_rel == RELCYC) begin
                        m_ph = 0; m_done = 1'b1;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare plus capture of what the DUT wrote into the RAM.
    logic [7:0] ram_q [16];
    int         pulses = 0;
    int         rst_cycles = 0;
    int         idle_load = 0;

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_ph == 1));
        chk("prog_mode", 32'(prog_mode), 32'(m_pm));
        chk("prog_addr", 32'(prog_addr), 32'(m_addr));
        chk("program_data", 32'(program_data), 32'(m_data));
        chk("cpu_halt", 32'(cpu_halt), 32'(m_ph != 0));
        chk("cpu_reset", 32'(cpu_reset), 32'(m_ph == 3));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("done", 32'(done), 32'(m_done));
        if (prog_mode) begin
            ram_q[prog_addr] = program_data;
            pulses++;
        end
        if (cpu_reset) rst_cycles++;
        if (in_ready && !in_valid) idle_load++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        for (int i = 0; i < 16; i++) ram_q[i] = 8'hEE;
        pulses = 0;
        rst_cycles = 0;
        idle_load = 0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_load(input string tag, input logic [7:0] exp_ram [16]);
        for (int i = 0; i < 16; i++) chk({tag, "_ram"}, 32'(ram_q[i]), 32'(exp_ram[i]));
        chk({tag, "_pulses"}, 32'(pulses), 32'd16);
        chk({tag, "_rst_cycles"}, 32'(rst_cycles), 32'd2);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_halt"}, 32'(cpu_halt), 32'd0);
    endtask

    logic [7:0] exp_ram [16];
    int         pulses_at_rst;

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_prog_mode", 32'(prog_mode), 32'd0);

        // load_abort outside LOAD must do nothing
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        step();
        chk("abort_idle_busy", 32'(busy), 32'd0);

        // Full load, bytes 0x10..0x1F back to back
        clear_capture();
        start_load();
        send_bytes(16, 8'h10);
        chk("full_in_ready_after_16", 32'(in_ready), 32'd0);
        wait_idle(20);
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h10 + 8'(i);
        check_load("full", exp_ram);

        // Timeout after three bytes
        clear_capture();
        start_load();
        send_bytes(3, 8'hA0);
        wait_idle(400);
        chk("timeout_idle_cycles", 32'(idle_load), 32'd255);
        for (int i = 0; i < 16; i++) exp_ram[i] = (i < 3) ? 8'hA0 + 8'(i) : 8'h00;
        check_load("timeout", exp_ram);

        // Abort with a concurrent transfer of 0xAA at index 5
        clear_capture();
        start_load();
        send_bytes(5, 8'h50);
        in_valid = 1'b1; in_data = 8'hAA; load_abort = 1'b1;
        step();
        in_valid = 1'b0; load_abort = 1'b0;
        wait_idle(30);
        for (int i = 0; i < 16; i++) exp_ram[i] = (i < 5) ? 8'h50 + 8'(i) : ((i == 5) ? 8'hAA : 8'h00);
        check_load("abort", exp_ram);

        // Backpressure: in_valid every other cycle
        clear_capture();
        start_load();
        for (int c = 0; c < 32; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = (c % 2 == 0) ? 8'h30 + 8'(c / 2) : 8'h5A;
            step();
        end
        in_valid = 1'b0;
        wait_idle(20);
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h30 + 8'(i);
        check_load("backpressure", exp_ram);

        // Reset in the middle of LOAD at index 7
        clear_capture();
        start_load();
        send_bytes(7, 8'h70);
        in_valid = 1'b1; in_data = 8'h77;
        rst = 1'b1;
        #2;
        chk("midrst_prog_mode", 32'(prog_mode), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_halt", 32'(cpu_halt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_addr", 32'(prog_addr), 32'd0);
        pulses_at_rst = pulses;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("midrst_no_more_pulses", 32'(pulses), 32'(pulses_at_rst));
        chk("midrst_done", 32'(done), 32'd0);
        clear_capture();
        start_load();
        send_bytes(16, 8'hC0);
        wait_idle(20);
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'hC0 + 8'(i);
        check_load("restart", exp_ram);

        // load_start during LOAD and during RELEASE is ignored
        clear_capture();
        start_load();
        send_bytes(4, 8'h80);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        send_bytes(12, 8'h84);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wait_idle(20);
        repeat (3) step();
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h80 + 8'(i);
        check_load("ignore_start", exp_ram);
        chk("ignore_start_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_prog_ctrl.md
RAM_PROG_CTRL -- requirements
Module: ram_prog_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: idle cycles in LOAD before auto-fill starts.
REQ-002 Parameter RELEASE_CYCLES, default 2: width of the cpu_reset pulse, in cycles.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 load_start  in  1  begins a program load; sampled only in IDLE.
REQ-006 load_abort  in  1  ends byte intake early; the remaining addresses are zero-filled.
REQ-007 in_valid  in  1  source has a byte on in_data.
REQ-008 in_data  in  8  program byte.
REQ-009 in_ready  out  1  block accepts a byte this cycle.
REQ-010 prog_mode  out  1  RAM program-write strobe.
REQ-011 prog_addr  out  4  RAM program address.
REQ-012 program_data  out  8  RAM program data.
REQ-013 cpu_halt  out  1  holds the CPU clock-enable off while high.
REQ-014 cpu_reset  out  1  CPU reset pulse issued after a load.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  sticky load-complete flag; cleared on the next accepted load_start.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, FILL and RELEASE.
REQ-018 IDLE: in_ready=0, prog_mode=0, cpu_halt=0, cpu_reset=0; load_start=1 -> LOAD with next address 0, done cleared, cpu_halt=1 from the next cycle.
REQ-019 LOAD: in_ready SHALL be 1 combinationally; a transfer occurs when in_valid and in_ready are both 1.
REQ-020 Each transfer SHALL drive prog_mode=1 for exactly the following cycle, with prog_addr equal to the transfer index and program_data equal to the captured in_data (1-cycle latency).
REQ-021 prog_mode SHALL be 0 on every cycle without a pending write; prog_addr and program_data hold their last values.
REQ-022 The transfer index SHALL increment after each write and never wrap; the 16th transfer (index 15) SHALL move the block to RELEASE, and in_ready SHALL be 0 from the next cycle.
REQ-023 A timeout counter SHALL clear on entry to LOAD and on each transfer, and increment on every other LOAD cycle; reaching TIMEOUT_CYCLES SHALL move the block to FILL.
REQ-024 If a transfer coincides with the timeout terminal count, the transfer SHALL win: the byte is written and the counter clears.
REQ-025 load_abort=1 in LOAD SHALL move the block to FILL; a transfer in the same cycle SHALL still be written, and fill starts at the next index.
REQ-026 FILL: in_ready=0; the block SHALL write 0x00 to each remaining index, one per cycle (prog_mode=1 each cycle), through index 15, then go to RELEASE.
REQ-027 If load_abort or the timeout occurs after index 15 has been written, the block SHALL go directly to RELEASE with no fill writes.
REQ-028 RELEASE: cpu_halt=1, cpu_reset=1 for exactly RELEASE_CYCLES cycles, then IDLE with done=1, cpu_halt=0 and cpu_reset=0 on the same edge.
REQ-029 load_start SHALL be ignored while busy=1; load_abort SHALL be ignored outside LOAD.
REQ-030 Exactly 16 prog_mode pulses SHALL occur per completed load, one per address 0..15, in ascending order.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE and set all outputs, the index and the timeout counter to 0.
REQ-032 Reset during LOAD or FILL SHALL abandon the load with no further writes; RAM contents are then partial and done stays 0.

Structure
REQ-033 Package ram_prog_pkg SHALL hold the state enum typedef, RAM_DEPTH=16, ADDR_W=4 and DATA_W=8.
REQ-034 The timeout counter SHALL be a sub-module named prog_timer, with clear/enable inputs and a terminal-count output.

Verification
REQ-035 Full load: load_start, then bytes 0x10..0x1F back-to-back -> 16 prog_mode pulses at addresses 0..15 with the matching data, in_ready low after the 16th transfer, cpu_reset high for 2 cycles, then done=1 and cpu_halt=0.
REQ-036 Timeout: 3 bytes, then in_valid held low -> after 255 idle cycles, addresses 3..15 are written with 0x00 and done=1.
REQ-037 Abort plus transfer in the same cycle with byte 0xAA at index 5 -> address 5 gets 0xAA, addresses 6..15 get 0x00.
REQ-038 Backpressure: in_valid toggled every other cycle -> only handshake cycles produce writes; each data value lands at the next address.
REQ-039 rst asserted mid-LOAD at index 7 -> outputs 0 asynchronously, no further prog_mode pulses, done=0; a new load_start restarts at address 0.
REQ-040 load_start pulsed during LOAD and during RELEASE -> no effect; the index and done are unchanged.
